// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction fetch sequencer. Walks one instruction at a time through
//   IDLE -> FETCH -> LOAD -> CHECK -> (ISSUE) -> NEXT -> FETCH ...
// FETCH waits ROM_LAT+1 cycles for the instruction ROM, LOAD strobes the
// instruction register, CHECK looks at the condition flag and either issues
// the instruction to the execute unit or skips it, and NEXT advances the PC.
// A halt request is only honoured at the instruction boundary (NEXT), so an
// instruction that has started fetching always completes with one IR load
// and one PC increment.
//
// Parameters
//   ROM_LAT    cycles from PC update to valid ROM data (1..3)
//   CNT_W      width of the issue/skip statistics counters
//
// Ports
//   clk        clock, rising edge
//   Rst        asynchronous reset, active low
//   start      level: begin/resume fetching from IDLE or HALTED
//   halt       level: stop at the next instruction boundary
//   flag       condition-pass from the instruction register (used in CHECK)
//   exec_done  execute unit finished the issued instruction (used in ISSUE)
//   Write_PC   PC increment enable
//   Write_IR   instruction register load enable
//   ir_valid   issued instruction presented to the execute unit
//   busy       high outside IDLE and HALTED
//   state      current state encoding, for debug
//   issue_cnt  saturating count of issued instructions
//   skip_cnt   saturating count of skipped instructions
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int ROM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             start,
  input  logic             halt,
  input  logic             flag,
  input  logic             exec_done,
  output logic             Write_PC,
  output logic             Write_IR,
  output logic             ir_valid,
  output logic             busy,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_CHECK   = 3'd3,
    S_ISSUE   = 3'd4,
    S_NEXT    = 3'd5,
    S_HALTED  = 3'd6,
    S_ILLEGAL = 3'd7
  } state_e;

  // Wait counter only needs to reach ROM_LAT (at most 3).
  localparam logic [1:0] LP_LAT = 2'(ROM_LAT);

  state_e           r_state;
  state_e           w_next_state;
  logic [1:0]       r_wait;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_skip_cnt;

  logic             w_fetch_done;
  logic             w_issue_inc;
  logic             w_skip_inc;

  assign w_fetch_done = (r_wait == LP_LAT);
  assign w_issue_inc  = (r_state == S_CHECK) &&  flag;
  assign w_skip_inc   = (r_state == S_CHECK) && !flag;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; blocking here would create order-
  // dependent simulation and a mismatch against the synthesized netlist.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of the block guarantees a value on
  // every path through the case, so no latch is inferred for w_next_state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        // halt is deliberately ignored here; only start matters.
        if (start) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (w_fetch_done) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_next_state = S_CHECK;
      end
      S_CHECK: begin
        w_next_state = flag ? S_ISSUE : S_NEXT;
      end
      S_ISSUE: begin
        if (exec_done) w_next_state = S_NEXT;
      end
      S_NEXT: begin
        // The only point where a pending halt takes effect.
        w_next_state = halt ? S_HALTED : S_FETCH;
      end
      S_HALTED: begin
        // halt dominates start when both are high.
        if (start && !halt) w_next_state = S_FETCH;
      end
      default: begin
        // Unused encoding 7 recovers to IDLE.
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: a pure function of the state register, so the strobes are
  // glitch-free with respect to inputs and mutually exclusive by construction.
  // ---------------------------------------------------------------------------
  always_comb begin
    Write_PC = 1'b0;
    Write_IR = 1'b0;
    ir_valid = 1'b0;
    busy     = 1'b1;
    case (r_state)
      S_LOAD:   Write_IR = 1'b1;
      S_ISSUE:  ir_valid = 1'b1;
      S_NEXT:   Write_PC = 1'b1;
      S_IDLE,
      S_HALTED: busy     = 1'b0;
      default:  ;
    endcase
  end

  assign state     = r_state;
  assign issue_cnt = r_issue_cnt;
  assign skip_cnt  = r_skip_cnt;

  // ---------------------------------------------------------------------------
  // ROM wait counter. Held at zero outside FETCH so it is already cleared on
  // every entry into FETCH; in FETCH it counts 0..ROM_LAT, giving ROM_LAT+1
  // cycles before LOAD. The wrap on the final FETCH cycle is harmless because
  // the next state is LOAD, where the counter is cleared anyway.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_wait <= 2'd0;
    end else if (r_state == S_FETCH) begin
      r_wait <= r_wait + 2'd1;
    end else begin
      r_wait <= 2'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics counters: saturate at all-ones, cleared only by reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_issue_cnt <= '0;
    end else if (w_issue_inc && (r_issue_cnt != {CNT_W{1'b1}})) begin
      r_issue_cnt <= r_issue_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_skip_cnt <= '0;
    end else if (w_skip_inc && (r_skip_cnt != {CNT_W{1'b1}})) begin
      r_skip_cnt <= r_skip_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl. dut0 uses the default ROM_LAT=1/CNT_W=16 and
// is driven from a vector table followed by hand-written sequences for the
// long ISSUE wait, halt at the instruction boundary, HALTED start/halt
// priority and asynchronous reset mid-LOAD. dut1 uses ROM_LAT=3/CNT_W=2 to
// cover the longer FETCH and counter saturation.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_ISSUE  = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;

  logic        clk;
  logic        Rst;

  logic        start0, halt0, flag0, ed0;
  logic        wpc0, wir0, irv0, busy0;
  logic [2:0]  st0;
  logic [15:0] ic0, sc0;

  logic        start1, halt1, flag1, ed1;
  logic        wpc1, wir1, irv1, busy1;
  logic [2:0]  st1;
  logic [1:0]  ic1, sc1;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_ctrl #(.ROM_LAT(1), .CNT_W(16)) dut0 (
    .clk(clk), .Rst(Rst), .start(start0), .halt(halt0), .flag(flag0),
    .exec_done(ed0), .Write_PC(wpc0), .Write_IR(wir0), .ir_valid(irv0),
    .busy(busy0), .state(st0), .issue_cnt(ic0), .skip_cnt(sc0)
  );

  fetch_ctrl #(.ROM_LAT(3), .CNT_W(2)) dut1 (
    .clk(clk), .Rst(Rst), .start(start1), .halt(halt1), .flag(flag1),
    .exec_done(ed1), .Write_PC(wpc1), .Write_IR(wir1), .ir_valid(irv1),
    .busy(busy1), .state(st1), .issue_cnt(ic1), .skip_cnt(sc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        halt;
    logic        flag;
    logic        ed;
    logic [2:0]  st;
    logic        wpc;
    logic        wir;
    logic        irv;
    logic        busy;
    logic [15:0] ic;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output check of dut0 against an expected state and strobe set.
  task automatic check0(input string tag, input logic [2:0] st, input logic wpc,
                        input logic wir, input logic irv, input logic busy,
                        input logic [15:0] ic, input logic [15:0] sc);
    check({tag, ".state"},    32'(st0),   32'(st));
    check({tag, ".Write_PC"}, 32'(wpc0),  32'(wpc));
    check({tag, ".Write_IR"}, 32'(wir0),  32'(wir));
    check({tag, ".ir_valid"}, 32'(irv0),  32'(irv));
    check({tag, ".busy"},     32'(busy0), 32'(busy));
    check({tag, ".issue_cnt"}, 32'(ic0),  32'(ic));
    check({tag, ".skip_cnt"},  32'(sc0),  32'(sc));
    check({tag, ".excl"}, 32'($countones({wpc0, wir0, irv0}) <= 1), 32'd1);
  endtask

  initial begin
    // ---------------- vector table (dut0, ROM_LAT=1) ------------------------
    //            start halt flag ed | state     wpc wir irv busy ic sc
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, ST_LOAD,  1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, ST_CHECK, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, ST_ISSUE, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, ST_NEXT,  1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0};
    // skipped instruction: flag=0 in CHECK goes straight to NEXT
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, ST_LOAD,  1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_CHECK, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_NEXT,  1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1};
    // halt raised in FETCH/LOAD/CHECK must not abort; exec_done outside ISSUE ignored
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, ST_LOAD,  1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, ST_CHECK, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, ST_ISSUE, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 16'd1};

    Rst    = 1'b0;
    start0 = 1'b0; halt0 = 1'b0; flag0 = 1'b0; ed0 = 1'b0;
    start1 = 1'b0; halt1 = 1'b0; flag1 = 1'b0; ed1 = 1'b0;

    // ---------------- reset state -------------------------------------------
    #2;
    check0("reset", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    #5 Rst = 1'b1;
    tick();
    check0("post_reset", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);

    // ---------------- table-driven vectors ----------------------------------
    for (int i = 0; i < 16; i++) begin
      start0 = tbl[i].start;
      halt0  = tbl[i].halt;
      flag0  = tbl[i].flag;
      ed0    = tbl[i].ed;
      tick();
      check0($sformatf("vec%0d", i), tbl[i].st, tbl[i].wpc, tbl[i].wir,
             tbl[i].irv, tbl[i].busy, tbl[i].ic, tbl[i].sc);
    end

    // ---------------- exec_done held low in ISSUE, halt pending -------------
    ed0 = 1'b0; halt0 = 1'b1; flag0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check0($sformatf("issue_wait%0d", i), ST_ISSUE, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 16'd1);
    end
    ed0 = 1'b1;
    tick();
    check0("issue_done", ST_NEXT, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 16'd1);
    ed0 = 1'b0;
    tick();
    check0("halted", ST_HALTED, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1);

    // ---------------- HALTED: halt wins over start --------------------------
    start0 = 1'b1; halt0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check0($sformatf("halt_wins%0d", i), ST_HALTED, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1);
    end
    halt0 = 1'b0;
    tick();
    check0("resume", ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 16'd1);
    start0 = 1'b0;
    tick();
    check0("resume_f2", ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 16'd1);
    tick();
    check0("resume_load", ST_LOAD, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 16'd1);

    // ---------------- asynchronous reset mid-LOAD ---------------------------
    #2 Rst = 1'b0;
    #1;
    check0("async_rst", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    #2 Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check0($sformatf("idle_after_rst%0d", i), ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    end
    start0 = 1'b1;
    tick();
    check0("restart", ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
    start0 = 1'b0;

    // ---------------- dut1: ROM_LAT=3, CNT_W=2 saturation -------------------
    start1 = 1'b1; flag1 = 1'b1; ed1 = 1'b1; halt1 = 1'b0;
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        check($sformatf("d1_i%0d_fetch%0d", n, k), 32'(st1), 32'(ST_FETCH));
      end
      tick();
      check($sformatf("d1_i%0d_load", n), 32'(st1), 32'(ST_LOAD));
      check($sformatf("d1_i%0d_wir", n), 32'(wir1), 32'd1);
      tick();
      check($sformatf("d1_i%0d_check", n), 32'(st1), 32'(ST_CHECK));
      tick();
      check($sformatf("d1_i%0d_issue", n), 32'(st1), 32'(ST_ISSUE));
      check($sformatf("d1_i%0d_ic", n), 32'(ic1), (n < 2) ? 32'(n + 1) : 32'd3);
      tick();
      check($sformatf("d1_i%0d_next", n), 32'(st1), 32'(ST_NEXT));
      check($sformatf("d1_i%0d_wpc", n), 32'(wpc1), 32'd1);
    end
    check("d1_ic_sat", 32'(ic1), 32'd3);
    check("d1_sc", 32'(sc1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
